multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 32-bit CPU datapath. It replaces single-cycle decode with an IF/ID/EX/MEM/WB state machine.
- Drives the same datapath control set as the single-cycle decoder: PCWre, InsMemRW, ExtSel, DataMemRW, ALUM2Reg, ALUSrcB, PCSrc, ALUOp, RegWre, RegOut.
- Adds an IR load strobe and a data-memory request/ready handshake.
- Sits between the instruction register / data memory and the shared PC, register file and ALU.

Parameters:
- HALT_OP, 6'b111111, opcode that parks the controller in HALT.
- MEM_TIMEOUT, 15, maximum wait cycles on mem_ready before the access is abandoned. 0 disables the timeout.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-low reset.
- op  input  6  opcode from the instruction register; valid from ID onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  data memory has completed the current access.
- IRWre  output  1  load the instruction register.
- InsMemRW  output  1  instruction memory read enable.
- PCWre  output  1  PC update strobe.
- PCSrc  output  1  1 = branch target, 0 = PC+4.
- ExtSel  output  1  1 = sign-extend immediate, 0 = zero-extend.
- ALUSrcB  output  1  1 = immediate, 0 = rt.
- ALUOp  output  4  ALU function; uses the shared ALU_* encodings.
- ALUM2Reg  output  1  1 = memory data to register file, 0 = ALU result.
- RegOut  output  1  1 = rd destination, 0 = rt destination.
- RegWre  output  1  register file write strobe.
- DataMemRW  output  1  1 = write, 0 = read.
- mem_req  output  1  data memory request, held until mem_ready or timeout.
- illegal_op  output  1  one-cycle pulse for an undefined opcode.
- mem_err  output  1  one-cycle pulse on memory timeout.
- halted  output  1  high while in HALT.

Behaviour:
- Reset:
  - Reset low at a clock edge puts the state in IF and clears the latched opcode and the wait counter.
  - While Reset is low, every output is forced to 0, including mid-instruction. No partial register or memory write may escape.
- States and transitions:
  - IF -> ID.
  - ID -> EX_AL for R-type or I-type ALU ops.
  - ID -> BR for BEQ or BNE.
  - ID -> EX_LS for LW or SW.
  - ID -> HALT for HALT_OP.
  - ID -> IF for any other opcode, with illegal_op=1 and PCWre=1 (NOP behaviour).
  - EX_AL -> WB_AL.
  - EX_LS -> MEM_RD for LW, MEM_WR for SW.
  - MEM_RD -> WB_LD on mem_ready.
  - MEM_WR -> IF on mem_ready.
  - BR, WB_AL and WB_LD -> IF.
  - HALT stays in HALT until Reset.
- Instruction latency, with 0 memory wait: ALU 4 cycles, branch 3, SW 4, LW 5. Each mem_ready wait cycle adds one.
- Per-state outputs (any signal not listed is 0):
  - IF: InsMemRW=1, IRWre=1.
  - ID: none.
  - EX_AL, EX_LS and BR: ALUOp, ALUSrcB, ExtSel and RegOut driven from the opcode latched at ID.
  - Those decode fields stay held through MEM and WB.
- Opcode classes:
  - R-type ALU (ADD, SUB, SLT, AND, NOR, OR, XOR, SLLV, SRAV, SRLV): RegOut=1, ALUSrcB=0.
  - ADDI, SUBI, SLTI: ExtSel=1, ALUSrcB=1.
  - ANDI, LUI, NORI, ORI, XORI: ExtSel=0, ALUSrcB=1.
  - LW and SW: ExtSel=1, ALUSrcB=1, ALUOp=ALU_ADD.
  - BEQ and BNE: ExtSel=1, ALUOp=ALU_SUB.
- Commit states:
  - WB_AL: RegWre=1, PCWre=1.
  - WB_LD: RegWre=1, ALUM2Reg=1, PCWre=1.
  - BR: PCWre=1, PCSrc=zero for BEQ, ~zero for BNE. PCSrc follows zero combinationally (Mealy output).
- Memory states:
  - MEM_RD: mem_req=1, DataMemRW=0.
  - MEM_WR: mem_req=1, DataMemRW=1. PCWre=1 in the cycle mem_ready is high.
  - mem_ready is ignored outside MEM_RD and MEM_WR.
- Timeout:
  - The wait counter increments each MEM cycle in which mem_ready is low.
  - When the counter equals MEM_TIMEOUT: mem_err=1, PCWre=1, no RegWre, next state IF.
  - If mem_ready and timeout coincide, mem_ready wins.
- PCWre is high in exactly one cycle per instruction; it is never high in HALT.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- Defined: adds outputs cyc_cnt[31:0] and ret_cnt[31:0], both cleared by Reset.
  - cyc_cnt increments every non-HALT cycle.
  - ret_cnt increments on every PCWre.
  - Both counters wrap at 2^32 without saturating.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - the opcode constants (ADD..SW and HALT);
  - the ALU_* encodings;
  - the state enum.
- One sub-module, mc_decode: purely combinational. It maps a latched opcode to {class, ALUOp, ALUSrcB, ExtSel, RegOut}.
- The state register, wait counter and output logic stay in multicycle_ctrl.

Test Plan:
- ADD (op 000000), Reset high:
  - IRWre in cycle 0; RegWre=1, RegOut=1, PCWre=1 in cycle 3 only; ALUOp=0000 in cycles 2-3.
- BEQ (010010):
  - zero=1 gives PCSrc=1, PCWre=1 in cycle 2.
  - Repeat with zero=0: PCSrc=0.
  - BNE with zero=0: PCSrc=1.
- LW (010100) with mem_ready low for 3 cycles:
  - mem_req high 4 cycles, DataMemRW=0, then WB_LD with ALUM2Reg=1, RegWre=1.
  - Total 8 cycles.
- SW (010101) with mem_ready never asserted, MEM_TIMEOUT=15:
  - mem_err pulse after 15 wait cycles, PCWre=1, RegWre never 1, return to IF.
- Illegal op 010110:
  - illegal_op=1 and PCWre=1 in the ID cycle, then IF.
  - Then op 111111: halted=1, PCWre stays 0 for 20 cycles.
- Reset low during WB_AL cycle:
  - RegWre and PCWre stay 0 that cycle; next cycle after release is IF with InsMemRW=1.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, ALU function encodings, controller states and decode records.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_defs_pkg;

    // R-type ALU opcodes
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_SLT  = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b000011;
    localparam logic [5:0] OP_NOR  = 6'b000100;
    localparam logic [5:0] OP_OR   = 6'b000101;
    localparam logic [5:0] OP_XOR  = 6'b000110;
    localparam logic [5:0] OP_SLLV = 6'b000111;
    localparam logic [5:0] OP_SRAV = 6'b001000;
    localparam logic [5:0] OP_SRLV = 6'b001001;
    // I-type ALU opcodes
    localparam logic [5:0] OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011;
    localparam logic [5:0] OP_SLTI = 6'b001100;
    localparam logic [5:0] OP_ANDI = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001110;
    localparam logic [5:0] OP_NORI = 6'b001111;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_XORI = 6'b010001;
    // Branches, memory, halt
    localparam logic [5:0] OP_BEQ  = 6'b010010;
    localparam logic [5:0] OP_BNE  = 6'b010011;
    localparam logic [5:0] OP_LW   = 6'b010100;
    localparam logic [5:0] OP_SW   = 6'b010101;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // ALU function encodings
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_LUI = 4'b1010;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EX_AL, S_WB_AL, S_BR, S_EX_LS, S_MEM_RD, S_MEM_WR, S_WB_LD, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_ILL, CL_ALU, CL_BR, CL_LS, CL_HALT
    } op_class_t;

    // Decoded fields of one opcode
    typedef struct packed {
        op_class_t  cls;
        logic [3:0] aluop;
        logic       alusrcb;
        logic       extsel;
        logic       regout;
    } dec_t;

    // Full datapath control set driven by the sequencer
    typedef struct packed {
        logic       irwre;
        logic       insmemrw;
        logic       pcwre;
        logic       pcsrc;
        logic       extsel;
        logic       alusrcb;
        logic [3:0] aluop;
        logic       alum2reg;
        logic       regout;
        logic       regwre;
        logic       datamemrw;
        logic       mem_req;
        logic       illegal_op;
        logic       mem_err;
        logic       halted;
    } ctl_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode decoder: maps an opcode to its class and ALU/operand/extension/destination fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module mc_decode
    import cpu_defs_pkg::*;
#(
    parameter logic [5:0] HALT_OP = OP_HALT
) (
    input  logic [5:0] op_i,
    output dec_t       dec_o
);

    // Class and operand selection first, then ALU function; halt opcode overrides everything
    always_comb begin
        dec_o = '{cls: CL_ILL, aluop: ALU_ADD, alusrcb: 1'b0, extsel: 1'b0, regout: 1'b0};
        case (op_i)
            OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_NOR,
            OP_OR, OP_XOR, OP_SLLV, OP_SRAV, OP_SRLV: begin
                dec_o.cls    = CL_ALU;
                dec_o.regout = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_SLTI: begin
                dec_o.cls     = CL_ALU;
                dec_o.extsel  = 1'b1;
                dec_o.alusrcb = 1'b1;
            end
            OP_ANDI, OP_LUI, OP_NORI, OP_ORI, OP_XORI: begin
                dec_o.cls     = CL_ALU;
                dec_o.alusrcb = 1'b1;
            end
            OP_LW, OP_SW: begin
                dec_o.cls     = CL_LS;
                dec_o.extsel  = 1'b1;
                dec_o.alusrcb = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_o.cls    = CL_BR;
                dec_o.extsel = 1'b1;
            end
            default: ;
        endcase
        case (op_i)
            OP_SUB, OP_SUBI, OP_BEQ, OP_BNE: dec_o.aluop = ALU_SUB;
            OP_SLT, OP_SLTI:                 dec_o.aluop = ALU_SLT;
            OP_AND, OP_ANDI:                 dec_o.aluop = ALU_AND;
            OP_NOR, OP_NORI:                 dec_o.aluop = ALU_NOR;
            OP_OR,  OP_ORI:                  dec_o.aluop = ALU_OR;
            OP_XOR, OP_XORI:                 dec_o.aluop = ALU_XOR;
            OP_SLLV:                         dec_o.aluop = ALU_SLL;
            OP_SRAV:                         dec_o.aluop = ALU_SRA;
            OP_SRLV:                         dec_o.aluop = ALU_SRL;
            OP_LUI:                          dec_o.aluop = ALU_LUI;
            default:                         dec_o.aluop = ALU_ADD;
        endcase
        if (op_i == HALT_OP) begin
            dec_o = '{cls: CL_HALT, aluop: ALU_ADD, alusrcb: 1'b0, extsel: 1'b0, regout: 1'b0};
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer driving the CPU datapath controls; MULTICYCLE_PERF_EN adds cycle/retire counters.
// Latency: ALU 4, branch 3, SW 4, LW 5 cycles, plus one per mem_ready wait cycle; illegal op 2 cycles.
// Backpressure: holds mem_req until mem_ready, abandoning the access after MEM_TIMEOUT wait cycles (0 = wait forever).
module multicycle_ctrl
    import cpu_defs_pkg::*;
#(
    parameter logic [5:0] HALT_OP     = OP_HALT,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       PCWre,
    output logic       PCSrc,
    output logic       ExtSel,
    output logic       ALUSrcB,
    output logic [3:0] ALUOp,
    output logic       ALUM2Reg,
    output logic       RegOut,
    output logic       RegWre,
    output logic       DataMemRW,
    output logic       mem_req,
    output logic       illegal_op,
    output logic       mem_err,
    output logic       halted
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t          state_q, state_d;
    logic [5:0]      op_q, op_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [5:0]      dec_op;
    dec_t            dec;
    ctl_t            ctl, ctl_g;
    logic            tmo;

    // In ID the opcode is still coming straight from the IR; afterwards the latched copy is used
    assign dec_op = (state_q == S_ID) ? op : op_q;

    mc_decode #(.HALT_OP(HALT_OP)) u_dec (
        .op_i  (dec_op),
        .dec_o (dec)
    );

    // mem_ready has priority over the timeout
    assign tmo = (MEM_TIMEOUT != 0) && (wait_q == WW'(MEM_TIMEOUT)) && !mem_ready;

    // State, latched opcode and wait counter registers
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= S_IF;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        ctl     = '0;
        state_d = state_q;
        op_d    = op_q;
        wait_d  = '0;
        // Decode fields are held from EX through the commit state
        if (state_q inside {S_EX_AL, S_WB_AL, S_BR, S_EX_LS, S_MEM_RD, S_MEM_WR, S_WB_LD}) begin
            ctl.aluop   = dec.aluop;
            ctl.alusrcb = dec.alusrcb;
            ctl.extsel  = dec.extsel;
            ctl.regout  = dec.regout;
        end
        case (state_q)
            S_IF: begin
                ctl.insmemrw = 1'b1;
                ctl.irwre    = 1'b1;
                state_d      = S_ID;
            end
            S_ID: begin
                op_d = op;
                case (dec.cls)
                    CL_ALU:  state_d = S_EX_AL;
                    CL_BR:   state_d = S_BR;
                    CL_LS:   state_d = S_EX_LS;
                    CL_HALT: state_d = S_HALT;
                    default: begin
                        ctl.illegal_op = 1'b1;
                        ctl.pcwre      = 1'b1;
                        state_d        = S_IF;
                    end
                endcase
            end
            S_EX_AL: state_d = S_WB_AL;
            S_WB_AL: begin
                ctl.regwre = 1'b1;
                ctl.pcwre  = 1'b1;
                state_d    = S_IF;
            end
            S_BR: begin
                ctl.pcwre = 1'b1;
                ctl.pcsrc = (op_q == OP_BNE) ? ~zero : zero;
                state_d   = S_IF;
            end
            S_EX_LS: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD, S_MEM_WR: begin
                ctl.mem_req   = 1'b1;
                ctl.datamemrw = (state_q == S_MEM_WR);
                if (mem_ready) begin
                    // A store commits here; a load still needs its write-back cycle
                    ctl.pcwre = (state_q == S_MEM_WR);
                    state_d   = (state_q == S_MEM_WR) ? S_IF : S_WB_LD;
                end else if (tmo) begin
                    ctl.mem_err = 1'b1;
                    ctl.pcwre   = 1'b1;
                    state_d     = S_IF;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WB_LD: begin
                ctl.regwre   = 1'b1;
                ctl.alum2reg = 1'b1;
                ctl.pcwre    = 1'b1;
                state_d      = S_IF;
            end
            S_HALT: ctl.halted = 1'b1;
            default: state_d = S_IF;
        endcase
    end

    // Reset masks every control immediately so no partial write escapes mid-instruction
    assign ctl_g      = Reset ? ctl : '0;
    assign IRWre      = ctl_g.irwre;
    assign InsMemRW   = ctl_g.insmemrw;
    assign PCWre      = ctl_g.pcwre;
    assign PCSrc      = ctl_g.pcsrc;
    assign ExtSel     = ctl_g.extsel;
    assign ALUSrcB    = ctl_g.alusrcb;
    assign ALUOp      = ctl_g.aluop;
    assign ALUM2Reg   = ctl_g.alum2reg;
    assign RegOut     = ctl_g.regout;
    assign RegWre     = ctl_g.regwre;
    assign DataMemRW  = ctl_g.datamemrw;
    assign mem_req    = ctl_g.mem_req;
    assign illegal_op = ctl_g.illegal_op;
    assign mem_err    = ctl_g.mem_err;
    assign halted     = ctl_g.halted;

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cyc_q, cyc_d, ret_q, ret_d;

    // Cycle counter runs outside HALT; retire counter ticks on each PC update; both wrap
    always_comb begin
        cyc_d = (state_q != S_HALT) ? cyc_q + 32'd1 : cyc_q;
        ret_d = ctl.pcwre ? ret_q + 32'd1 : ret_q;
    end

    // Performance counter registers
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: drives one instruction at a time and compares the full control vector each cycle.
// Latency: inputs applied on the falling edge, outputs sampled 1 time unit later.
// Backpressure: mem_ready driven directly per cycle from the stimulus.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       IRWre, InsMemRW, PCWre, PCSrc, ExtSel, ALUSrcB;
    logic [3:0] ALUOp;
    logic       ALUM2Reg, RegOut, RegWre, DataMemRW, mem_req, illegal_op, mem_err, halted;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    always #5 CLK = ~CLK;

    multicycle_ctrl #(.HALT_OP(6'b111111), .MEM_TIMEOUT(15)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .IRWre      (IRWre),
        .InsMemRW   (InsMemRW),
        .PCWre      (PCWre),
        .PCSrc      (PCSrc),
        .ExtSel     (ExtSel),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ALUM2Reg   (ALUM2Reg),
        .RegOut     (RegOut),
        .RegWre     (RegWre),
        .DataMemRW  (DataMemRW),
        .mem_req    (mem_req),
        .illegal_op (illegal_op),
        .mem_err    (mem_err),
        .halted     (halted)
`ifdef MULTICYCLE_PERF_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .ret_cnt    (ret_cnt)
`endif
    );

    // Observed control vector, MSB first
    logic [17:0] outs;
    assign outs = {IRWre, InsMemRW, PCWre, PCSrc, ExtSel, ALUSrcB, ALUOp,
                   ALUM2Reg, RegOut, RegWre, DataMemRW, mem_req, illegal_op, mem_err, halted};

    localparam logic [17:0] NONE = 18'h00000;
    localparam logic [17:0] IRW  = 18'h20000;
    localparam logic [17:0] INS  = 18'h10000;
    localparam logic [17:0] PCW  = 18'h08000;
    localparam logic [17:0] PCS  = 18'h04000;
    localparam logic [17:0] EXT  = 18'h02000;
    localparam logic [17:0] ASB  = 18'h01000;
    localparam logic [17:0] A_SUB = 18'h00100;
    localparam logic [17:0] A_OR  = 18'h00500;
    localparam logic [17:0] M2R  = 18'h00080;
    localparam logic [17:0] RGO  = 18'h00040;
    localparam logic [17:0] RGW  = 18'h00020;
    localparam logic [17:0] DMW  = 18'h00010;
    localparam logic [17:0] REQ  = 18'h00008;
    localparam logic [17:0] ILL  = 18'h00004;
    localparam logic [17:0] ERR  = 18'h00002;
    localparam logic [17:0] HLT  = 18'h00001;
    localparam logic [17:0] FETCH = IRW | INS;

    localparam logic [5:0] ADD  = 6'b000000;
    localparam logic [5:0] SUB  = 6'b000001;
    localparam logic [5:0] ADDI = 6'b001010;
    localparam logic [5:0] ORI  = 6'b010000;
    localparam logic [5:0] BEQ  = 6'b010010;
    localparam logic [5:0] BNE  = 6'b010011;
    localparam logic [5:0] LW   = 6'b010100;
    localparam logic [5:0] SW   = 6'b010101;
    localparam logic [5:0] BAD  = 6'b010110;
    localparam logic [5:0] HALT = 6'b111111;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One clock cycle: apply inputs on the falling edge, then compare the control vector
    task automatic step(input logic rst, input logic [5:0] o, input logic z, input logic mr,
                        input logic [17:0] exp, input string tag);
        @(negedge CLK);
        Reset     = rst;
        op        = o;
        zero      = z;
        mem_ready = mr;
        #1;
        check(tag, {14'b0, outs}, {14'b0, exp});
    endtask

    initial begin
        Reset     = 1'b0;
        op        = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        // Reset state: everything low
        step(0, ADD, 0, 0, NONE, "rst0");
        step(0, ADD, 1, 1, NONE, "rst1");

        // ADD: R-type, writes rd in cycle 3
        step(1, ADD, 0, 0, FETCH, "add_if");
        step(1, ADD, 0, 0, NONE, "add_id");
        step(1, ADD, 0, 0, RGO, "add_ex");
        step(1, ADD, 0, 0, RGO | RGW | PCW, "add_wb");

        // SUB: ALU function follows opcode
        step(1, SUB, 0, 0, FETCH, "sub_if");
        step(1, SUB, 0, 0, NONE, "sub_id");
        step(1, SUB, 0, 0, RGO | A_SUB, "sub_ex");
        step(1, SUB, 0, 0, RGO | A_SUB | RGW | PCW, "sub_wb");

        // ADDI: sign-extended immediate
        step(1, ADDI, 0, 0, FETCH, "addi_if");
        step(1, ADDI, 0, 0, NONE, "addi_id");
        step(1, ADDI, 0, 0, EXT | ASB, "addi_ex");
        step(1, ADDI, 0, 0, EXT | ASB | RGW | PCW, "addi_wb");

        // ORI: zero-extended immediate
        step(1, ORI, 0, 0, FETCH, "ori_if");
        step(1, ORI, 0, 0, NONE, "ori_id");
        step(1, ORI, 0, 0, ASB | A_OR, "ori_ex");
        step(1, ORI, 0, 0, ASB | A_OR | RGW | PCW, "ori_wb");

        // BEQ taken / not taken
        step(1, BEQ, 1, 0, FETCH, "beq1_if");
        step(1, BEQ, 1, 0, NONE, "beq1_id");
        step(1, BEQ, 1, 0, EXT | A_SUB | PCW | PCS, "beq1_br");
        step(1, BEQ, 0, 0, FETCH, "beq0_if");
        step(1, BEQ, 0, 0, NONE, "beq0_id");
        step(1, BEQ, 0, 0, EXT | A_SUB | PCW, "beq0_br");

        // BNE taken, then zero flips inside the branch cycle
        step(1, BNE, 0, 0, FETCH, "bne_if");
        step(1, BNE, 0, 0, NONE, "bne_id");
        step(1, BNE, 0, 0, EXT | A_SUB | PCW | PCS, "bne_br");
        zero = 1'b1;
        #1;
        check("bne_mealy", {31'b0, PCSrc}, 32'd0);

        // LW with three wait cycles: 8 cycles total
        step(1, LW, 0, 0, FETCH, "lw_if");
        step(1, LW, 0, 0, NONE, "lw_id");
        step(1, LW, 0, 0, EXT | ASB, "lw_ex");
        for (int i = 0; i < 3; i++)
            step(1, LW, 0, 0, EXT | ASB | REQ, $sformatf("lw_wait%0d", i));
        step(1, LW, 0, 1, EXT | ASB | REQ, "lw_rdy");
        step(1, LW, 0, 0, EXT | ASB | M2R | RGW | PCW, "lw_wb");

        // SW with immediate ready
        step(1, SW, 0, 1, FETCH, "sw_if");
        step(1, SW, 0, 1, NONE, "sw_id");
        step(1, SW, 0, 1, EXT | ASB, "sw_ex");
        step(1, SW, 0, 1, EXT | ASB | REQ | DMW | PCW, "sw_mem");

        // SW never acknowledged: 15 wait cycles then the timeout cycle
        step(1, SW, 0, 0, FETCH, "swto_if");
        step(1, SW, 0, 0, NONE, "swto_id");
        step(1, SW, 0, 0, EXT | ASB, "swto_ex");
        for (int i = 0; i < 15; i++)
            step(1, SW, 0, 0, EXT | ASB | REQ | DMW, $sformatf("swto_wait%0d", i));
        step(1, SW, 0, 0, EXT | ASB | REQ | DMW | ERR | PCW, "swto_err");

        // Illegal opcode behaves as a NOP with a pulse
        step(1, BAD, 0, 0, FETCH, "ill_if");
        step(1, BAD, 0, 0, ILL | PCW, "ill_id");

        // Halt: parked, no PC update, mem_ready ignored
        step(1, HALT, 0, 0, FETCH, "hlt_if");
        step(1, HALT, 0, 0, NONE, "hlt_id");
        for (int i = 0; i < 20; i++)
            step(1, HALT, 0, i[0], HLT, $sformatf("hlt%0d", i));

        // Reset leaves HALT
        step(0, ADD, 0, 0, NONE, "hlt_rst");

        // Reset asserted in the write-back cycle suppresses the commit
        step(1, ADD, 0, 0, FETCH, "rwb_if");
        step(1, ADD, 0, 0, NONE, "rwb_id");
        step(1, ADD, 0, 0, RGO, "rwb_ex");
        step(0, ADD, 0, 0, NONE, "rwb_wb_masked");
        step(1, ADD, 0, 0, FETCH, "rwb_refetch");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
